multiword_adder_ctrl: RTL

Sequential multi-precision adder controller. It adds two WORDS×N-bit operands one N-bit word per cycle, least-significant word first. Each word pair goes through an internal `carry_skip_adder` instance, and the registered `cout` of each word becomes `cin` of the next. It sits directly around the carry-skip adder stage: it feeds the adder operands and carry-in, and it consumes `sum`/`cout`. It also provides valid/ready streaming on both sides.

---
 rtl/multiword_adder_ctrl.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/multiword_adder_ctrl.sv
// Sequential multi-precision adder: WORDS x N-bit operands summed one word per cycle, LSW first,
// with valid/ready streaming. Define MULTIWORD_OVF_EN to add the signed-overflow output `ovf`.

module carry_skip_adder #(
    parameter int N          = 8,
    parameter int BLOCK_SIZE = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);
    logic c;
    logic blk_cin;
    logic blk_p;

    // Ripple inside each block; a block whose bits all propagate forwards its carry-in directly.
    always_comb begin
        // NOTE: every variable gets a value before any branch so no latch is inferred.
        sum     = '0;
        c       = cin;
        blk_cin = cin;
        blk_p   = 1'b1;
        for (int i = 0; i < N; i++) begin
            sum[i] = a[i] ^ b[i] ^ c;
            c      = (a[i] & b[i]) | ((a[i] ^ b[i]) & c);
            blk_p  = blk_p & (a[i] ^ b[i]);
            if ((i % BLOCK_SIZE == BLOCK_SIZE - 1) || (i == N - 1)) begin
                if (blk_p) c = blk_cin;
                blk_cin = c;
                blk_p   = 1'b1;
            end
        end
        cout = c;
    end
endmodule

module multiword_adder_ctrl #(
    parameter int N          = 8,
    parameter int BLOCK_SIZE = 4,
    parameter int WORDS      = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         cin_init,
    input  logic [N-1:0] a_word,
    input  logic [N-1:0] b_word,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [N-1:0] sum_word,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         last,
    output logic         cout_final,
    output logic         busy
`ifdef MULTIWORD_OVF_EN
    ,
    output logic         ovf
`endif
);
    localparam int CW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(WORDS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state, state_next;
    logic          carry;
    logic [CW-1:0] cnt;
    logic [N-1:0]  add_sum;
    logic          add_cout;
    logic          accept;
    logic          final_word;

    carry_skip_adder #(
        .N          (N),
        .BLOCK_SIZE (BLOCK_SIZE)
    ) u_adder (
        .a    (a_word),
        .b    (b_word),
        .cin  (carry),
        .sum  (add_sum),
        .cout (add_cout)
    );

    assign accept     = in_valid && in_ready;
    assign final_word = accept && (cnt == LAST_IDX);

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        busy       = (state != IDLE);
        case (state)
            IDLE: if (start) state_next = RUN;
            RUN: begin
                in_ready = !out_valid || out_ready;
                if (in_valid && in_ready && (cnt == LAST_IDX)) state_next = DONE;
            end
            DONE: if (out_valid && out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            state <= IDLE;
            carry <= 1'b0;
            cnt   <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && start) begin
                carry <= cin_init;
                cnt   <= '0;
            end else if (accept) begin
                carry <= add_cout;
                cnt   <= cnt + CW'(1);
            end
        end
    end

    // An accept overwrites the output register even while it drains, so there is no bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_word   <= '0;
            out_valid  <= 1'b0;
            last       <= 1'b0;
            cout_final <= 1'b0;
        end else if (accept) begin
            sum_word   <= add_sum;
            out_valid  <= 1'b1;
            last       <= final_word;
            cout_final <= final_word && add_cout;
        end else if (out_ready) begin
            sum_word   <= '0;
            out_valid  <= 1'b0;
            last       <= 1'b0;
            cout_final <= 1'b0;
        end
    end

`ifdef MULTIWORD_OVF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (accept) begin
            ovf <= final_word && (a_word[N-1] == b_word[N-1]) && (add_sum[N-1] != a_word[N-1]);
        end else if (out_ready) begin
            ovf <= 1'b0;
        end
    end
`endif
endmodule
